// File: rtl/sseg_demux_capture.sv
// Captures the digits of a multiplexed 4-digit seven-segment display into per-digit registers.
// Optional hex decode outputs are enabled by defining SSEG_CAPTURE_HEX_DECODE_EN.
module sseg_demux_capture #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ce,
   input  logic [3:0] i_sseg_enables,
   input  logic [6:0] i_sseg,
   output logic [6:0] o_digit_1,
   output logic [6:0] o_digit_2,
   output logic [6:0] o_digit_3,
   output logic [6:0] o_digit_4,
   output logic [3:0] o_digit_valid,
   output logic       o_frame_done,
   output logic       o_error,
   output logic [7:0] o_err_count
`ifdef SSEG_CAPTURE_HEX_DECODE_EN
   ,
   output logic [3:0] o_hex_1,
   output logic [3:0] o_hex_2,
   output logic [3:0] o_hex_3,
   output logic [3:0] o_hex_4,
   output logic [3:0] o_hex_ok
`endif
);

   localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] ref_en;
   logic [6:0] ref_seg;
   logic [3:0] seen_mask;
   logic       legal, same;
   logic       load_ref, latch, err_evt;

   assign legal = $onehot(i_sseg_enables);
   assign same  = (i_sseg_enables == ref_en) && (i_sseg == ref_seg);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load_ref  = 1'b0;
      latch     = 1'b0;
      err_evt   = 1'b0;
      if (i_ce) begin
         if (!legal) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_evt   = 1'b1;
         end else if (state == SETTLE && same) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt_nxt == SETTLE_N) begin
               latch     = 1'b1;
               state_nxt = HOLD;
            end
         end else if (state == HOLD && same) begin
            state_nxt = HOLD;
         end else begin
            // New candidate digit: IDLE, or a changed sample in SETTLE/HOLD
            load_ref = 1'b1;
            cnt_nxt  = 4'd1;
            if (SETTLE_N == 4'd1) begin
               latch     = 1'b1;
               state_nxt = HOLD;
            end else begin
               state_nxt = SETTLE;
            end
         end
      end
   end

`ifdef SSEG_CAPTURE_HEX_DECODE_EN
   // Returns {ok, hex}
   function automatic logic [4:0] hex_decode(input logic [6:0] seg);
      case (seg)
         7'h3F: hex_decode = {1'b1, 4'h0};
         7'h06: hex_decode = {1'b1, 4'h1};
         7'h5B: hex_decode = {1'b1, 4'h2};
         7'h4F: hex_decode = {1'b1, 4'h3};
         7'h66: hex_decode = {1'b1, 4'h4};
         7'h6D: hex_decode = {1'b1, 4'h5};
         7'h7D: hex_decode = {1'b1, 4'h6};
         7'h07: hex_decode = {1'b1, 4'h7};
         7'h7F: hex_decode = {1'b1, 4'h8};
         7'h6F: hex_decode = {1'b1, 4'h9};
         7'h77: hex_decode = {1'b1, 4'hA};
         7'h7C: hex_decode = {1'b1, 4'hB};
         7'h39: hex_decode = {1'b1, 4'hC};
         7'h5E: hex_decode = {1'b1, 4'hD};
         7'h79: hex_decode = {1'b1, 4'hE};
         7'h71: hex_decode = {1'b1, 4'hF};
         default: hex_decode = 5'b0;
      endcase
   endfunction

   logic [4:0] hex_dec;
   assign hex_dec = hex_decode(i_sseg);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_hex_1  <= '0;
         o_hex_2  <= '0;
         o_hex_3  <= '0;
         o_hex_4  <= '0;
         o_hex_ok <= '0;
      end else if (latch) begin
         case (i_sseg_enables)
            4'b0001: begin o_hex_1 <= hex_dec[3:0]; o_hex_ok[0] <= hex_dec[4]; end
            4'b0010: begin o_hex_2 <= hex_dec[3:0]; o_hex_ok[1] <= hex_dec[4]; end
            4'b0100: begin o_hex_3 <= hex_dec[3:0]; o_hex_ok[2] <= hex_dec[4]; end
            4'b1000: begin o_hex_4 <= hex_dec[3:0]; o_hex_ok[3] <= hex_dec[4]; end
            default: ;
         endcase
      end
   end
`endif

   // On a latch cycle the live sample always equals the reference, so it is written directly
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ref_en        <= '0;
         ref_seg       <= '0;
         seen_mask     <= '0;
         o_digit_1     <= '0;
         o_digit_2     <= '0;
         o_digit_3     <= '0;
         o_digit_4     <= '0;
         o_digit_valid <= '0;
         o_frame_done  <= 1'b0;
         o_error       <= 1'b0;
         o_err_count   <= '0;
      end else begin
         o_frame_done <= 1'b0;
         o_error      <= 1'b0;
         if (load_ref) begin
            ref_en  <= i_sseg_enables;
            ref_seg <= i_sseg;
         end
         if (err_evt) begin
            o_error <= 1'b1;
            if (o_err_count != 8'hFF)
               o_err_count <= o_err_count + 8'd1;
         end
         if (latch) begin
            case (i_sseg_enables)
               4'b0001: o_digit_1 <= i_sseg;
               4'b0010: o_digit_2 <= i_sseg;
               4'b0100: o_digit_3 <= i_sseg;
               4'b1000: o_digit_4 <= i_sseg;
               default: ;
            endcase
            o_digit_valid <= o_digit_valid | i_sseg_enables;
            if (i_sseg_enables[3]) begin
               o_frame_done <= (seen_mask[2:0] == 3'b111);
               seen_mask    <= '0;
            end else begin
               seen_mask <= seen_mask | i_sseg_enables;
            end
         end
      end
   end

endmodule

// File: tb/tb_sseg_demux_capture.sv
// Directed self-checking bench for sseg_demux_capture (SETTLE_CYCLES = 2).
module tb_sseg_demux_capture;

   logic       clk = 1'b0;
   logic       reset, ce;
   logic [3:0] en;
   logic [6:0] seg;
   logic [6:0] d1, d2, d3, d4;
   logic [3:0] valid;
   logic       fd, err;
   logic [7:0] errc;
`ifdef SSEG_CAPTURE_HEX_DECODE_EN
   logic [3:0] h1, h2, h3, h4, hok;
`endif

   int checks = 0;
   int failures = 0;

   sseg_demux_capture #(.SETTLE_CYCLES(2)) dut (
      .i_clk(clk), .i_reset(reset), .i_ce(ce),
      .i_sseg_enables(en), .i_sseg(seg),
      .o_digit_1(d1), .o_digit_2(d2), .o_digit_3(d3), .o_digit_4(d4),
      .o_digit_valid(valid), .o_frame_done(fd), .o_error(err), .o_err_count(errc)
`ifdef SSEG_CAPTURE_HEX_DECODE_EN
      , .o_hex_1(h1), .o_hex_2(h2), .o_hex_3(h3), .o_hex_4(h4), .o_hex_ok(hok)
`endif
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, outputs checked 1ns after the edge
   task automatic cyc(input logic c, input logic [3:0] e, input logic [6:0] s);
      ce = c; en = e; seg = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0, 4'b0000, 7'h00);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({d1, d2, d3, d4} !== 28'h0 || valid !== 4'h0 || fd !== 1'b0 || err !== 1'b0 || errc !== 8'h0) begin
         failures++;
         $display("FAIL reset_state got d=%h valid=%b fd=%b err=%b errc=%0d exp all zero",
                  {d1, d2, d3, d4}, valid, fd, err, errc);
      end
   endtask

   task automatic test_basic();
      do_reset();
      cyc(1'b1, 4'b0001, 7'h06);
      checks++;
      if (valid !== 4'b0000) begin
         failures++; $display("FAIL basic_first_sample valid=%b exp=0000", valid);
      end
      cyc(1'b1, 4'b0001, 7'h06);
      checks++;
      if (d1 !== 7'h06 || valid !== 4'b0001) begin
         failures++; $display("FAIL basic_latch d1=%h valid=%b exp d1=06 valid=0001", d1, valid);
      end
      checks++;
      if (fd !== 1'b0) begin
         failures++; $display("FAIL basic_no_frame fd=%b exp=0", fd);
      end
   endtask

   task automatic test_frame();
      logic [6:0] segs [4];
      int pulses;
      logic last_fd;
      segs = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
      pulses = 0;
      last_fd = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 2; j++) begin
            cyc(1'b1, 4'(1 << i), segs[i]);
            if (fd === 1'b1) pulses++;
            last_fd = fd;
         end
      end
      checks++;
      if (pulses != 1 || last_fd !== 1'b1) begin
         failures++; $display("FAIL frame_pulse pulses=%0d last_fd=%b exp 1 pulse on digit4 latch", pulses, last_fd);
      end
      checks++;
      if (d1 !== 7'h3F || d2 !== 7'h06 || d3 !== 7'h5B || d4 !== 7'h4F || valid !== 4'b1111) begin
         failures++; $display("FAIL frame_digits got %h %h %h %h valid=%b exp 3f 06 5b 4f 1111", d1, d2, d3, d4, valid);
      end
`ifdef SSEG_CAPTURE_HEX_DECODE_EN
      checks++;
      if (h1 !== 4'h0 || h2 !== 4'h1 || h3 !== 4'h2 || h4 !== 4'h3 || hok !== 4'b1111) begin
         failures++; $display("FAIL frame_hex got %h %h %h %h ok=%b exp 0 1 2 3 1111", h1, h2, h3, h4, hok);
      end
`endif
      // Holding digit 4 must neither re-latch nor pulse again
      cyc(1'b1, 4'b1000, 7'h4F);
      checks++;
      if (fd !== 1'b0) begin
         failures++; $display("FAIL frame_hold_no_pulse fd=%b exp=0", fd);
      end
   endtask

   task automatic test_error();
      cyc(1'b1, 4'b0011, 7'h7F);
      checks++;
      if (err !== 1'b1 || errc !== 8'd1) begin
         failures++; $display("FAIL error_pulse err=%b errc=%0d exp err=1 errc=1", err, errc);
      end
      checks++;
      if (d1 !== 7'h3F || d2 !== 7'h06 || valid !== 4'b1111) begin
         failures++; $display("FAIL error_digits_kept d1=%h d2=%h valid=%b exp 3f 06 1111", d1, d2, valid);
      end
      cyc(1'b0, 4'b0011, 7'h7F);
      checks++;
      if (err !== 1'b0 || errc !== 8'd1) begin
         failures++; $display("FAIL error_one_pulse err=%b errc=%0d exp err=0 errc=1", err, errc);
      end
      repeat (300) cyc(1'b1, 4'b0000, 7'h00);
      checks++;
      if (errc !== 8'd255) begin
         failures++; $display("FAIL error_saturate errc=%0d exp=255", errc);
      end
      checks++;
      if (d4 !== 7'h4F || valid !== 4'b1111) begin
         failures++; $display("FAIL error_sat_digits_kept d4=%h valid=%b exp 4f 1111", d4, valid);
      end
   endtask

   task automatic test_reload();
      do_reset();
      cyc(1'b1, 4'b0010, 7'h06);
      cyc(1'b1, 4'b0010, 7'h5B);
      checks++;
      if (valid !== 4'b0000 || d2 !== 7'h00) begin
         failures++; $display("FAIL reload_no_early_latch valid=%b d2=%h exp 0000 00", valid, d2);
      end
      cyc(1'b1, 4'b0010, 7'h5B);
      checks++;
      if (valid !== 4'b0010 || d2 !== 7'h5B) begin
         failures++; $display("FAIL reload_latch valid=%b d2=%h exp 0010 5b", valid, d2);
      end
   endtask

   task automatic test_reset_settle();
      // Enter SETTLE with nonzero outputs still present
      cyc(1'b1, 4'b1000, 7'h06);
      cyc(1'b1, 4'b1000, 7'h06);
      cyc(1'b1, 4'b0011, 7'h00);
      cyc(1'b1, 4'b0100, 7'h5B);
      reset = 1'b1;
      cyc(1'b0, 4'b0100, 7'h5B);
      reset = 1'b0;
      checks++;
      if ({d1, d2, d3, d4} !== 28'h0 || valid !== 4'h0 || fd !== 1'b0 || err !== 1'b0 || errc !== 8'h0) begin
         failures++;
         $display("FAIL reset_in_settle d=%h valid=%b fd=%b err=%b errc=%0d exp all zero",
                  {d1, d2, d3, d4}, valid, fd, err, errc);
      end
      cyc(1'b1, 4'b0100, 7'h5B);
      checks++;
      if (valid !== 4'b0000) begin
         failures++; $display("FAIL reset_discards_pending valid=%b exp=0000", valid);
      end
      cyc(1'b1, 4'b0100, 7'h5B);
      checks++;
      if (valid !== 4'b0100 || d3 !== 7'h5B) begin
         failures++; $display("FAIL reset_then_latch valid=%b d3=%h exp 0100 5b", valid, d3);
      end
   endtask

   task automatic test_ce_gating();
      do_reset();
      cyc(1'b1, 4'b1000, 7'h7F);
      cyc(1'b0, 4'b1000, 7'h7F);
      cyc(1'b0, 4'b1000, 7'h7F);
      checks++;
      if (valid !== 4'b0000) begin
         failures++; $display("FAIL ce_no_latch_on_clocks valid=%b exp=0000", valid);
      end
      cyc(1'b1, 4'b1000, 7'h7F);
      checks++;
      if (valid !== 4'b1000 || d4 !== 7'h7F || fd !== 1'b0) begin
         failures++; $display("FAIL ce_latch valid=%b d4=%h fd=%b exp 1000 7f 0", valid, d4, fd);
      end
   endtask

   task automatic test_frame_order();
      int pulses;
      // Continues from digit 4 latched alone: mask was cleared, so 3,1,2 then 4 completes a frame
      pulses = 0;
      cyc(1'b1, 4'b0100, 7'h66); cyc(1'b1, 4'b0100, 7'h66);
      cyc(1'b1, 4'b0001, 7'h6D); cyc(1'b1, 4'b0001, 7'h6D);
      cyc(1'b1, 4'b0010, 7'h7D); cyc(1'b1, 4'b0010, 7'h7D);
      cyc(1'b1, 4'b1000, 7'h07);
      if (fd === 1'b1) pulses++;
      cyc(1'b1, 4'b1000, 7'h07);
      checks++;
      if (fd !== 1'b1 || pulses != 0) begin
         failures++; $display("FAIL order_frame fd=%b early=%0d exp fd=1 early=0", fd, pulses);
      end
      // Only digits 1,2 then 4: incomplete frame, no pulse
      cyc(1'b1, 4'b0001, 7'h3F); cyc(1'b1, 4'b0001, 7'h3F);
      cyc(1'b1, 4'b0010, 7'h06); cyc(1'b1, 4'b0010, 7'h06);
      cyc(1'b1, 4'b1000, 7'h79); cyc(1'b1, 4'b1000, 7'h79);
      checks++;
      if (fd !== 1'b0 || d4 !== 7'h79) begin
         failures++; $display("FAIL incomplete_frame fd=%b d4=%h exp 0 79", fd, d4);
      end
`ifdef SSEG_CAPTURE_HEX_DECODE_EN
      checks++;
      if (h4 !== 4'hE || h3 !== 4'h4 || hok !== 4'b1111) begin
         failures++; $display("FAIL order_hex h4=%h h3=%h ok=%b exp e 4 1111", h4, h3, hok);
      end
`endif
   endtask

   initial begin
      reset = 1'b1; ce = 1'b0; en = '0; seg = '0;
      #1;
      test_reset();
      test_basic();
      test_frame();
      test_error();
      test_reset_settle();
      test_reload();
      test_ce_gating();
      test_frame_order();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sseg_demux_capture.md
SSEG_DEMUX_CAPTURE -- requirements
Module: sseg_demux_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15; consecutive identical samples required before a digit is latched.
REQ-002 SHALL have port i_clk, input, 1, system clock; all logic rises on i_clk.
REQ-003 SHALL have port i_reset, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port i_ce, input, 1, sample enable; inputs sampled only on cycles with i_ce=1.
REQ-005 SHALL have port i_sseg_enables, input, 4, multiplexed digit enables, active-high, bit k-1 selects digit k.
REQ-006 SHALL have port i_sseg, input, 7, shared segment bus, bit0=a .. bit6=g, active-high.
REQ-007 SHALL have ports o_digit_1..o_digit_4, output, 7 each, last latched segment pattern per digit.
REQ-008 SHALL have port o_digit_valid, output, 4, bit k-1 set once digit k has been latched since reset.
REQ-009 SHALL have port o_frame_done, output, 1, one-cycle pulse on frame completion.
REQ-010 SHALL have port o_error, output, 1, one-cycle pulse on an illegal enable sample.
REQ-011 SHALL have port o_err_count, output, 8, saturating count of illegal enable samples.
REQ-012 Inputs SHALL be synchronous to i_clk; the block SHALL NOT include synchronizers.

Function
REQ-013 Sample SHALL be legal when i_sseg_enables is exactly one-hot; zero or multiple bits set is illegal.
REQ-014 FSM states SHALL be IDLE, SETTLE, HOLD; transitions evaluated only on i_ce=1 cycles; i_ce=0 holds all state.
REQ-015 Illegal sample, any state: next state IDLE, settle count cleared, o_error pulses next cycle, o_err_count increments and saturates at 255.
REQ-016 IDLE, legal sample: store enables and segments as reference, count=1, go SETTLE; if SETTLE_CYCLES=1, latch immediately and go HOLD.
REQ-017 SETTLE, legal sample equal to reference (enables and segments): count increments; on reaching SETTLE_CYCLES latch and go HOLD.
REQ-018 SETTLE, legal sample differing from reference: reload reference, count=1, stay SETTLE (or latch per REQ-016 when SETTLE_CYCLES=1).
REQ-019 HOLD, legal sample equal to reference: stay HOLD, no re-latch; differing: behave as IDLE with that sample.
REQ-020 Latch SHALL write reference segments to o_digit_k, set o_digit_valid[k-1]; outputs visible one clock after the deciding sample.
REQ-021 A seen-mask SHALL record digits latched since last frame_done; o_frame_done pulses with the latch of digit 4 when digits 1..3 are already in the mask, then the mask clears.
REQ-022 Digit 4 latched with mask incomplete: no pulse, mask clears; latch order otherwise unconstrained.
REQ-023 Illegal sample SHALL NOT alter o_digit_k, o_digit_valid or the seen-mask.

Reset
REQ-024 i_reset=1 SHALL, at the next i_clk edge regardless of i_ce: state IDLE, count 0, reference 0, mask 0, all o_digit_k 0, o_digit_valid 0, o_frame_done 0, o_error 0, o_err_count 0.
REQ-025 Reset mid-SETTLE SHALL discard the pending digit; reset takes priority over any simultaneous sample.

Configuration
REQ-026 Macro SSEG_CAPTURE_HEX_DECODE_EN defined: SHALL add outputs o_hex_1..o_hex_4 (4 bits) and o_hex_ok (4 bits), registered with the digit latch.
REQ-027 Decode table: 3F=0,06=1,5B=2,4F=3,66=4,6D=5,7D=6,07=7,7F=8,6F=9,77=A,7C=b,39=C,5E=d,79=E,71=F; other patterns: hex 0, ok bit 0; reset values 0.
REQ-028 Macro undefined: hex ports and decode logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 SETTLE_CYCLES=2, i_ce=1, enables 0001 seg 06 for 2 cycles -> o_digit_1=06, o_digit_valid=0001 after the second sample.
REQ-030 Enables 0001,0010,0100,1000 each for 2 samples with segs 3F,06,5B,4F -> single o_frame_done pulse with digit 4 latch; hex 0,1,2,3 when macro defined.
REQ-031 Enables 0011 for 1 sample -> o_error one pulse, o_err_count=1, digits unchanged; 300 illegal samples -> o_err_count=255.
REQ-032 Enables 0010 seg 06 then seg 5B (1 sample each) then 5B again -> only 5B latched to o_digit_2.
REQ-033 i_reset asserted in SETTLE with i_ce=0 -> all outputs 0 next cycle, no latch afterwards.
REQ-034 i_ce toggled 1/0 alternately with valid stable input -> latch after 2 i_ce=1 samples, not 2 clocks.
